// File: rtl/register_file_wb.sv
// Integer register file with write-through bypass and a per-register
// pending-write scoreboard for RAW hazard detection at decode.
module register_file_wb #(
    parameter int XLEN   = 64,
    parameter int PEND_W = 2,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_stall,
    output logic            hazard1,
    output logic            hazard2,
    input  logic [4:0]      WriteReg,
    input  logic [XLEN-1:0] WriteData,
    input  logic            regWrite
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);
    localparam bit                BYP     = (BYPASS != 0);

    logic [XLEN-1:0]   r_regs [32];
    logic [PEND_W-1:0] r_cnt  [32];

    logic w_wr_en;
    logic w_inc;
    logic w_dec;

    function automatic logic [XLEN-1:0] f_read(
        input logic [4:0]      a,
        input logic [XLEN-1:0] stored,
        input logic            wr_en,
        input logic [4:0]      wreg,
        input logic [XLEN-1:0] wdata
    );
        if (a == 5'd0)
            f_read = '0;
        else if (BYP && wr_en && wreg == a)
            f_read = wdata;
        else
            f_read = stored;
    endfunction

    // The last outstanding write being bypassed this cycle satisfies the read.
    function automatic logic f_hazard(
        input logic [4:0]        a,
        input logic [PEND_W-1:0] c,
        input logic              wr_en,
        input logic [4:0]        wreg
    );
        f_hazard = (a != 5'd0) && (c != '0) &&
                   !(BYP && c == CNT_ONE && wr_en && wreg == a);
    endfunction

    assign w_wr_en = regWrite && (WriteReg != 5'd0);

    assign issue_stall = issue_valid && (issue_rd != 5'd0) &&
                         (r_cnt[issue_rd] == CNT_MAX);

    assign w_inc = issue_valid && (issue_rd != 5'd0) && !issue_stall;
    assign w_dec = w_wr_en && (r_cnt[WriteReg] != '0);

    assign ReadData1 = f_read(rs1, r_regs[rs1], w_wr_en, WriteReg, WriteData);
    assign ReadData2 = f_read(rs2, r_regs[rs2], w_wr_en, WriteReg, WriteData);

    assign hazard1 = f_hazard(rs1, r_cnt[rs1], w_wr_en, WriteReg);
    assign hazard2 = f_hazard(rs2, r_cnt[rs2], w_wr_en, WriteReg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            if (w_wr_en)
                r_regs[WriteReg] <= WriteData;
            // Entry 0 is never touched so x0 and its counter stay zero.
            for (int i = 1; i < 32; i++) begin
                if (w_inc && issue_rd == 5'(i) &&
                    !(w_dec && WriteReg == 5'(i)))
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                else if (w_dec && WriteReg == 5'(i) &&
                         !(w_inc && issue_rd == 5'(i)))
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_register_file_wb.sv
// Directed bench for register_file_wb: expected values are queued when
// stimulus is driven and popped when the DUT output is sampled.
module tb_register_file_wb;

    localparam int XLEN = 64;

    logic            clk;
    logic            reset;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_stall;
    logic            hazard1;
    logic            hazard2;
    logic [4:0]      WriteReg;
    logic [XLEN-1:0] WriteData;
    logic            regWrite;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t q_exp[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    register_file_wb #(.XLEN(XLEN), .PEND_W(2), .BYPASS(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs1         (rs1),
        .rs2         (rs2),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .regWrite    (regWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q_exp.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        n_assert++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required an entry", obs);
        end else begin
            e = q_exp.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        regWrite    = 1'b0;
        WriteReg    = 5'd0;
        WriteData   = '0;
    endtask

    initial begin
        reset = 1'b1;
        rs1   = 5'd0;
        rs2   = 5'd0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state across all addresses
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rs1 = 5'(a);
            rs2 = 5'(a);
            #1;
            push($sformatf("rst_rd1_x%0d", a), 64'd0);
            pop_chk(ReadData1);
        end
        push("rst_haz1", 64'd0);  pop_chk(64'(hazard1));
        push("rst_haz2", 64'd0);  pop_chk(64'(hazard2));
        push("rst_stall", 64'd0); pop_chk(64'(issue_stall));

        // write x5 with same-cycle bypass
        @(negedge clk);
        regWrite = 1'b1; WriteReg = 5'd5;
        WriteData = 64'hDEAD_BEEF_0123_4567; rs1 = 5'd5;
        #1;
        push("byp_x5", 64'hDEAD_BEEF_0123_4567); pop_chk(ReadData1);
        push("byp_x5_haz", 64'd0);               pop_chk(64'(hazard1));
        @(negedge clk);
        idle_inputs();
        #1;
        push("stored_x5", 64'hDEAD_BEEF_0123_4567); pop_chk(ReadData1);

        // write to x0 is dropped
        @(negedge clk);
        regWrite = 1'b1; WriteReg = 5'd0; WriteData = '1; rs2 = 5'd0;
        #1;
        push("x0_byp", 64'd0); pop_chk(ReadData2);
        push("x0_haz", 64'd0); pop_chk(64'(hazard2));
        @(negedge clk);
        idle_inputs();
        #1;
        push("x0_after", 64'd0); pop_chk(ReadData2);

        // two in-flight writes to x7
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        #1;
        push("x7_iss1_haz", 64'd0);   pop_chk(64'(hazard1));
        push("x7_iss1_stall", 64'd0); pop_chk(64'(issue_stall));
        @(negedge clk);
        #1;
        push("x7_iss2_haz", 64'd1); pop_chk(64'(hazard1));
        @(negedge clk);
        idle_inputs();
        regWrite = 1'b1; WriteReg = 5'd7; WriteData = 64'hA1A1;
        #1;
        push("x7_wb1_haz", 64'd1);    pop_chk(64'(hazard1));
        push("x7_wb1_byp", 64'hA1A1); pop_chk(ReadData1);
        @(negedge clk);
        idle_inputs();
        #1;
        push("x7_mid_haz", 64'd1);    pop_chk(64'(hazard1));
        push("x7_mid_rd", 64'hA1A1);  pop_chk(ReadData1);
        @(negedge clk);
        regWrite = 1'b1; WriteReg = 5'd7; WriteData = 64'hB2B2;
        #1;
        push("x7_wb2_haz", 64'd0);    pop_chk(64'(hazard1));
        push("x7_wb2_byp", 64'hB2B2); pop_chk(ReadData1);
        @(negedge clk);
        idle_inputs();
        #1;
        push("x7_done_haz", 64'd0);   pop_chk(64'(hazard1));
        push("x7_done_rd", 64'hB2B2); pop_chk(ReadData1);

        // x9: simultaneous issue+writeback, then saturation
        rs2 = 5'd9;
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        regWrite = 1'b1; WriteReg = 5'd9; WriteData = 64'h99;
        #1;
        push("x9_same_haz", 64'd0);  pop_chk(64'(hazard2));
        push("x9_same_rd", 64'h99);  pop_chk(ReadData2);
        @(negedge clk);
        regWrite = 1'b0;
        #1;
        push("x9_c1_haz", 64'd1);   pop_chk(64'(hazard2));
        push("x9_c1_stall", 64'd0); pop_chk(64'(issue_stall));
        @(negedge clk);
        #1;
        push("x9_c2_stall", 64'd0); pop_chk(64'(issue_stall));
        @(negedge clk);
        #1;
        push("x9_c3_stall", 64'd1); pop_chk(64'(issue_stall));
        @(negedge clk);
        #1;
        push("x9_c3_hold", 64'd1);  pop_chk(64'(issue_stall));
        @(negedge clk);
        idle_inputs();
        regWrite = 1'b1; WriteReg = 5'd9; WriteData = 64'h91;
        #1;
        push("x9_wb_c3_haz", 64'd1); pop_chk(64'(hazard2));
        @(negedge clk);
        WriteData = 64'h92;
        #1;
        push("x9_wb_c2_haz", 64'd1); pop_chk(64'(hazard2));
        @(negedge clk);
        WriteData = 64'h93;
        #1;
        push("x9_wb_c1_haz", 64'd0); pop_chk(64'(hazard2));
        @(negedge clk);
        idle_inputs();
        #1;
        push("x9_c0_haz", 64'd0);  pop_chk(64'(hazard2));
        push("x9_c0_rd", 64'h93);  pop_chk(ReadData2);

        // mid-cycle asynchronous reset
        @(negedge clk);
        regWrite = 1'b1; WriteReg = 5'd3; WriteData = 64'h1234;
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd3;
        #1;
        push("x3_rd", 64'h1234); pop_chk(ReadData1);
        push("x3_pre_haz", 64'd0); pop_chk(64'(hazard1));
        @(negedge clk);
        idle_inputs();
        #1;
        push("x3_haz", 64'd1); pop_chk(64'(hazard1));
        #2;
        reset = 1'b1;
        #1;
        push("arst_rd", 64'd0);  pop_chk(ReadData1);
        push("arst_haz", 64'd0); pop_chk(64'(hazard1));
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd3;
        regWrite = 1'b1; WriteReg = 5'd4; WriteData = 64'hBAD;
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        rs2 = 5'd4;
        #1;
        push("rst_nowr", 64'd0);   pop_chk(ReadData2);
        push("rst_noiss", 64'd0);  pop_chk(64'(hazard1));
        @(negedge clk);
        regWrite = 1'b1; WriteReg = 5'd3; WriteData = 64'h55;
        @(negedge clk);
        idle_inputs();
        #1;
        push("post_rst_wr", 64'h55); pop_chk(ReadData1);

        n_assert++;
        assert (q_exp.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left required 0", q_exp.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
